// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a single synchronous ROM.
// Each grant performs one three-cycle read and returns the data with a one-cycle ack.
module rom_arbiter #(
  parameter int KB    = 16,
  parameter int FIXED = 0,
  localparam int AW   = $clog2(KB * 1024)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic [AW-1:0] a0,
  output logic          ack0,
  output logic [7:0]    q0,
  input  logic          req1,
  input  logic [AW-1:0] a1,
  output logic          ack1,
  output logic [7:0]    q1,
  output logic [AW-1:0] rom_a,
  input  logic [7:0]    rom_q,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StRead, StCapture} state_t;

  state_t state;
  logic   g;
  logic   last;
  logic   win;

  // On a tie the port not served last wins, unless port 0 has fixed priority.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = (FIXED != 0) ? 1'b0 : ~last;
    end else begin
      win = req1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= StIdle;
      rom_a <= '0;
      g     <= 1'b0;
      last  <= 1'b1;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      q0    <= 8'h00;
      q1    <= 8'h00;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        StIdle: begin
          if (req0 || req1) begin
            g     <= win;
            rom_a <= win ? a1 : a0;
            state <= StRead;
          end
        end
        StRead: begin
          state <= StCapture;
        end
        StCapture: begin
          if (g) begin
            q1   <= rom_q;
            ack1 <= 1'b1;
          end else begin
            q0   <= rom_q;
            ack0 <= 1'b1;
          end
          last  <= g;
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign busy = (state != StIdle);

endmodule
